cprv_scoreboard: RTL
====================

# cprv_scoreboard

Register scoreboard and issue controller for the in-order pipeline. It sits beside `cprv_id_stage` and tracks, per architectural register, how many writes are in flight between ID issue and WB retire. It withholds the ID→EX handshake while a source or destination hazard exists, and releases it when WB retires the pending write. It also provides flush, error and stall-statistics outputs to the core controller.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: register address width; 2**REG_ADDR_WIDTH registers tracked.
- `CNT_WIDTH`, 2: per-register pending-write counter width; maximum outstanding writes per register = 2**CNT_WIDTH-1.
- `STALL_CNT_WIDTH`, 32: width of the stall statistics counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_id_i`  in  1  ID holds a decoded instruction.
- `ready_id_i`  in  1  ID stage's own clock enable (`~valid_ex | ready_ex`).
- `rs1_addr_i`  in  REG_ADDR_WIDTH  source 1 address from ID.
- `rs2_addr_i`  in  REG_ADDR_WIDTH  source 2 address from ID.
- `rs1_used_i`  in  1  instruction reads rs1.
- `rs2_used_i`  in  1  instruction reads rs2.
- `rd_addr_i`  in  REG_ADDR_WIDTH  destination address from ID.
- `rd_en_i`  in  1  instruction writes rd.
- `issue_ok_o`  out  1  no hazard; ID may hand off to EX.
- `issue_fire_o`  out  1  equals `valid_id_i & ready_id_i & issue_ok_o`.
- `wb_valid_i`  in  1  WB writes the register file this cycle.
- `wb_rd_addr_i`  in  REG_ADDR_WIDTH  WB destination address.
- `flush_i`  in  1  pipeline flush; discard all pending writes.
- `busy_o`  out  1  at least one counter is nonzero.
- `err_o`  out  1  sticky flag: retire arrived while the counter was 0.
- `stall_cnt_o`  out  STALL_CNT_WIDTH  cycles with `valid_id_i & ~issue_ok_o`, saturating.

## Operation
- State: `cnt[r]` for r = 1..2**REG_ADDR_WIDTH-1. Register x0 is never tracked and always reads 0. Addresses of 0 never cause hazards and never change state.
- Source hazard: `rsN_used_i` is set and `cnt[rsN] != 0`.
- Destination hazard: `rd_en_i` is set and `cnt[rd]` is at its maximum value (saturated).
- `issue_ok_o = ~(any hazard)`. The value is combinational from registered counters and current inputs.
- Increment event: `issue_fire_o & rd_en_i & rd != 0`.
- Decrement event: `wb_valid_i & wb_rd_addr_i != 0`.
- Both events on the same register in the same cycle leave `cnt` unchanged.
- Decrement on a counter that is 0: the counter stays 0 and `err_o` sets. `err_o` clears only on `rst`.
- `flush_i` zeroes every counter on the next edge and takes priority over same-cycle increment and decrement. `issue_fire_o` is still reported as computed; the flushed instruction is discarded by the pipeline.
- `stall_cnt_o` increments once per cycle while `valid_id_i & ~issue_ok_o`. It holds at all-ones and is not affected by `flush_i`.
- Reset values: all `cnt` = 0, `busy_o` = 0, `err_o` = 0, `stall_cnt_o` = 0. `issue_ok_o` is therefore 1 immediately after reset. A reset asserted mid-stall releases the stall asynchronously.

## Timing
- Hazard detection to `issue_ok_o`: 0 cycles (combinational).
- Counter update: 1 cycle. An instruction issued in cycle t makes a dependent instruction stall from cycle t+1.
- Without bypass, a retire in cycle t releases the stall in cycle t+1.
- `busy_o` and `err_o` are registered-state derived and valid the cycle after the causing event.

## Configuration
- Macro `CPRV_SCOREBOARD_BYPASS_EN`.
- Defined: a source hazard is suppressed in the same cycle as the retire when `cnt[rs] == 1` and `wb_valid_i` targets that rs. The register-file write-through supplies the value, so the stall releases in cycle t.
- Undefined: the stall releases in cycle t+1, as described in Timing.
- Destination saturation checks are identical in both configurations.

## Structure
- Shared package `cprv_pkg`:
  - opcode constants (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE);
  - `reg_addr_t` typedef;
  - `sb_cnt_t` typedef.
- Sub-module `cprv_sb_entry`: one per tracked register. It holds the counter and computes inc/dec/flush/saturate/underflow. It exports `nonzero`, `one` and `full`. The top level instantiates it with a generate loop from 1 to 2**REG_ADDR_WIDTH-1.

## Test plan
- Reset, then an instruction with rs1=3, rs2=4 and rd=5 issues → `issue_ok_o`=1, `cnt[5]`=1, `busy_o`=1 in the next cycle.
- A dependent instruction with rs1=5 follows, and WB retires x5 three cycles later:
  - without bypass, the stall lasts until the cycle after the retire, and `stall_cnt_o`=4;
  - with the macro defined, `stall_cnt_o`=3.
- Issue rd=7 three times with no retire; a fourth instruction with rd=7 → `issue_ok_o`=0 (saturated). One retire of x7 → the fourth instruction issues the next cycle.
- Issue rd=9 and retire x9 in the same cycle while `cnt[9]`=1 → `cnt[9]` stays 1.
- `wb_valid_i` with rd=12 while `cnt[12]`=0 → `err_o`=1 the next cycle and remains set. An instruction with rd=0 and rs1=0 → never stalls, and `busy_o` is unchanged.
- With counters 2, 4 and 6 nonzero, assert `flush_i` together with an issue to rd=8 → all counters are 0, `busy_o`=0, and `stall_cnt_o` is unchanged.

Source files
------------

// File: rtl/cprv_pkg.sv
// Shared core package: opcode constants and scoreboard-related types.
package cprv_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned SB_CNT_W   = 2;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

endpackage

// File: rtl/cprv_sb_entry.sv
// Per-register pending-write counter with flush, saturation and underflow detection.
module cprv_sb_entry
   import cprv_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic dec_i,
   input  logic flush_i,
   output logic nonzero_o,
   output logic one_o,
   output logic full_o,
   output logic underflow_c_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign nonzero_o = |cnt_q;
   assign one_o     = (cnt_q == CNT_WIDTH'(1));
   assign full_o    = &cnt_q;

   // A retire with nothing pending and no same-cycle issue to balance it.
   assign underflow_c_o = dec_i && !inc_i && !nonzero_o;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (!full_o) cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (dec_i && !inc_i) begin
         if (nonzero_o) cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cprv_scoreboard.sv
// Register scoreboard / issue controller; CPRV_SCOREBOARD_BYPASS_EN enables
// same-cycle release of a source hazard when WB retires the last pending write.
module cprv_scoreboard
   import cprv_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH  = 5,
   parameter int unsigned CNT_WIDTH       = 2,
   parameter int unsigned STALL_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_id_i,
   input  logic                       ready_id_i,
   input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_i,
   input  logic                       rs1_used_i,
   input  logic                       rs2_used_i,
   input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_i,
   input  logic                       rd_en_i,
   output logic                       issue_ok_o,
   output logic                       issue_fire_o,
   input  logic                       wb_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr_i,
   input  logic                       flush_i,
   output logic                       busy_o,
   output logic                       err_o,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

   localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;
`ifdef CPRV_SCOREBOARD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [NUM_REGS-1:0] nonzero, one, full, underflow;
   logic                rs1_haz, rs2_haz, rd_haz;
   logic                err_q, err_d;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // x0 is never tracked.
   assign nonzero[0]   = 1'b0;
   assign one[0]       = 1'b0;
   assign full[0]      = 1'b0;
   assign underflow[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      cprv_sb_entry #(.CNT_WIDTH(CNT_WIDTH)) u_entry (
         .clk           (clk),
         .rst           (rst),
         .inc_i         (issue_fire_o && rd_en_i && (rd_addr_i == REG_ADDR_WIDTH'(r))),
         .dec_i         (wb_valid_i && (wb_rd_addr_i == REG_ADDR_WIDTH'(r))),
         .flush_i       (flush_i),
         .nonzero_o     (nonzero[r]),
         .one_o         (one[r]),
         .full_o        (full[r]),
         .underflow_c_o (underflow[r])
      );
   end

   // Hazard detection from registered counters and current ID/WB inputs.
   always_comb begin
      rs1_haz = rs1_used_i && nonzero[rs1_addr_i];
      rs2_haz = rs2_used_i && nonzero[rs2_addr_i];
      rd_haz  = rd_en_i && full[rd_addr_i];
      if (BYPASS && wb_valid_i && (wb_rd_addr_i == rs1_addr_i) && one[rs1_addr_i])
         rs1_haz = 1'b0;
      if (BYPASS && wb_valid_i && (wb_rd_addr_i == rs2_addr_i) && one[rs2_addr_i])
         rs2_haz = 1'b0;
   end

   assign issue_ok_o   = !(rs1_haz || rs2_haz || rd_haz);
   assign issue_fire_o = valid_id_i && ready_id_i && issue_ok_o;
   assign busy_o       = |nonzero;
   assign err_o        = err_q;
   assign stall_cnt_o  = stall_cnt_q;

   always_comb begin
      err_d       = err_q | (|underflow);
      stall_cnt_d = stall_cnt_q;
      if (valid_id_i && !issue_ok_o && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
